rs232_rx_buffer: RTL and testbench

//  Receive-side byte buffer between the RS232R receiver and the processor I/O bus
//  (data word 2, status word 3). It drains each received byte from RS232R through
//  its rdy/done handshake into a FIFO, then serves the bytes to software in arrival order.
//  It also keeps a sticky overrun flag, so software polling slowly no longer drops

---
 rtl/rs232_rx_buffer_pkg.sv | 32 +++
 rtl/rs232_rx_buffer_if.sv | 33 +++
 rtl/rs232_rx_buffer_fifo.sv | 68 ++++++
 rtl/rs232_rx_buffer.sv | 88 ++++++++
 tb/tb_rs232_rx_buffer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rs232_rx_buffer_pkg.sv
// Shared constants for the RS232 receive path: I/O word addresses, status bits, FSM codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rs232_pkg;

  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DATA_W         = 8;

  // Processor I/O word addresses served by the receive path.
  localparam int IOADR_RSDATA   = 2;
  localparam int IOADR_RSCTRL   = 3;

  // Status word layout: bit 0 = byte available, bit 2 = sticky overrun.
  localparam int STAT_RDY_BIT   = 0;
  localparam int STAT_OVR_BIT   = 2;

  // Ingest FSM encoding, kept as plain constants so older code can compare against it.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  typedef logic [DATA_W-1:0] rx_byte_t;

  // Builds the status word seen by software from the buffer flags.
  function automatic logic [7:0] status_word(input logic nonempty, input logic overrun);
    logic [7:0] w;
    w               = '0;
    w[STAT_RDY_BIT] = nonempty;
    w[STAT_OVR_BIT] = overrun;
    return w;
  endfunction

endpackage

// File: rtl/rs232_rx_buffer_if.sv
// Bundles the receiver handshake and the CPU-side read/status signals of the rx buffer.
// Latency: n/a (wiring only).
// Backpressure: receiver side uses rdy/done; CPU side is strobe-based and never stalls.
interface rs232_rx_buffer_if #(parameter int DEPTH_LOG2 = rs232_pkg::DEF_DEPTH_LOG2);
  import rs232_pkg::*;

  // Receiver (RS232R) side
  logic                rx_rdy;
  rx_byte_t            rx_data;
  logic                rx_done;

  // CPU bus side
  logic                rd_pop;
  logic                clr_ovr;
  rx_byte_t            rd_data;
  logic                nonempty;
  logic                full;
  logic                overrun;
  logic [DEPTH_LOG2:0] count;

  // Driver of the buffer: receiver plus bus decode.
  modport master (
    output rx_rdy, rx_data, rd_pop, clr_ovr,
    input  rx_done, rd_data, nonempty, full, overrun, count
  );

  // The buffer itself.
  modport slave (
    input  rx_rdy, rx_data, rd_pop, clr_ovr,
    output rx_done, rd_data, nonempty, full, overrun, count
  );

endinterface

// File: rtl/rs232_rx_buffer_fifo.sv
// Generic synchronous FIFO with first-word fall-through head and occupancy count.
// Latency: write visible at head/count one clock after wr_en; pop takes effect on the clock edge.
// Backpressure: writes are dropped when full unless a pop frees the slot in the same cycle.
module fifo_sync #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  rd_ok;
  logic                  wr_ok;

  // A pop on an empty FIFO is ignored; a write into a full FIFO only lands if a pop
  // vacates a slot on the same edge.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Storage array is left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  // Write pointer, wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        wptr <= '0;
    else if (wr_ok) wptr <= wptr + 1'b1;
  end

  // Read pointer, wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rptr <= '0;
    else if (rd_ok) rptr <= rptr + 1'b1;
  end

  // Occupancy: simultaneous write and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign count = cnt;
  assign full  = (cnt == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/rs232_rx_buffer.sv
// Drains bytes from the RS232 receiver into a FIFO and serves them to the CPU with a sticky overrun flag.
// Latency: byte captured on the first edge with rx_rdy high in IDLE; nonempty/rx_done visible after that edge.
// Backpressure: receiver is always acked; a byte arriving while full with no pop is discarded and flagged.
module rs232_rx_buffer
  import rs232_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  rs232_rx_buffer_if.slave  bus
);

  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic                rx_done_q;
  logic                overrun_q;

  logic                offer;
  logic                wr_en;
  logic                rd_en;
  logic                discard;

  rx_byte_t            head;
  logic [DEPTH_LOG2:0] cnt;
  logic                f_full;
  logic                f_empty;

  // A byte is only taken in IDLE; the ACK cycle gives the receiver time to drop rdy,
  // which is what prevents the same byte from being captured twice.
  assign offer   = (state == ST_IDLE) & bus.rx_rdy;
  assign rd_en   = bus.rd_pop & ~f_empty;
  // When full, a same-cycle pop frees the slot, so the byte is kept rather than lost.
  assign wr_en   = offer & (~f_full | bus.rd_pop);
  assign discard = offer & f_full & ~bus.rd_pop;

  // Next-state logic for the two-state ingest handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.rx_rdy) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered done pulse (one cycle, never back-to-back).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rx_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_done_q <= offer;
    end
  end

  // Sticky overrun: a discard in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun_q <= 1'b0;
    else if (discard)     overrun_q <= 1'b1;
    else if (bus.clr_ovr) overrun_q <= 1'b0;
  end

  fifo_sync #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (bus.rx_data),
    .rd_en   (rd_en),
    .head    (head),
    .count   (cnt),
    .full    (f_full),
    .empty   (f_empty)
  );

  // Head byte is masked to zero when empty so software never sees stale RAM contents.
  assign bus.rd_data  = f_empty ? '0 : head;
  assign bus.rx_done  = rx_done_q;
  assign bus.nonempty = ~f_empty;
  assign bus.full     = f_full;
  assign bus.overrun  = overrun_q;
  assign bus.count    = cnt;

endmodule

// File: tb/tb_rs232_rx_buffer.sv
// Self-checking bench for rs232_rx_buffer: vector table, directed corner sequences, random vs queue model.
module tb_rs232_rx_buffer;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rs232_rx_buffer_if #(.DEPTH_LOG2(DL2)) bus();

  rs232_rx_buffer #(.DEPTH_LOG2(DL2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       pop;
    logic       clr;
    logic       e_done;
    int         e_count;
    logic [7:0] e_rd;
    logic       e_ovr;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic [7:0] d, input logic pop, input logic clr);
    bus.rx_rdy  = rdy;
    bus.rx_data = d;
    bus.rd_pop  = pop;
    bus.clr_ovr = clr;
  endtask

  // Apply inputs for exactly one clock, then return inputs to idle just after the edge.
  task automatic cyc(input logic rdy, input logic [7:0] d, input logic pop, input logic clr);
    drive(rdy, d, pop, clr);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Receiver delivers one byte: rdy for one cycle, dropped during the ack cycle.
  task automatic push_byte(input string tag, input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
    chk({tag, "_done_hi"}, bus.rx_done, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk({tag, "_done_lo"}, bus.rx_done, 0);
  endtask

  task automatic fill16(input string tag);
    for (int i = 0; i < DEPTH; i++) push_byte(tag, 8'(i));
    chk({tag, "_count"}, bus.count, DEPTH);
    chk({tag, "_full"}, bus.full, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random-phase model state
  byte unsigned q[$];
  bit           m_ovr;
  bit           taken;
  bit           held_once;
  bit           pending;
  logic         r_rdy, r_pop, r_clr;
  logic [7:0]   r_data;
  int           pop_div;
  int           exp_head;

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // ---- reset state ----
    reset_dut();
    chk("rst_done",     bus.rx_done,  0);
    chk("rst_count",    bus.count,    0);
    chk("rst_nonempty", bus.nonempty, 0);
    chk("rst_full",     bus.full,     0);
    chk("rst_ovr",      bus.overrun,  0);
    chk("rst_rd_data",  bus.rd_data,  0);

    // ---- table: single byte, pop, empty pop, write+pop on empty, clear ----
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1, 8'h41, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 8'h41, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 1, 8'h7E, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 8'h7E, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].rdy, tbl[i].data, tbl[i].pop, tbl[i].clr);
      chk($sformatf("tbl%0d_done", i),     bus.rx_done,  tbl[i].e_done);
      chk($sformatf("tbl%0d_count", i),    bus.count,    tbl[i].e_count);
      chk($sformatf("tbl%0d_nonempty", i), bus.nonempty, tbl[i].e_count > 0);
      chk($sformatf("tbl%0d_full", i),     bus.full,     tbl[i].e_count == DEPTH);
      chk($sformatf("tbl%0d_rd_data", i),  bus.rd_data,  tbl[i].e_rd);
      chk($sformatf("tbl%0d_ovr", i),      bus.overrun,  tbl[i].e_ovr);
    end

    // ---- fill and overrun ----
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      push_byte("fill", 8'(i));
      chk("fill_count", bus.count, i + 1);
      chk("fill_full",  bus.full,  i == DEPTH - 1);
    end
    push_byte("ovr17", 8'h10);
    chk("ovr17_overrun", bus.overrun, 1);
    chk("ovr17_count",   bus.count,   DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", bus.rd_data, i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_count",    bus.count,    0);
    chk("drain_nonempty", bus.nonempty, 0);
    chk("drain_rd_zero",  bus.rd_data,  0);
    chk("drain_ovr_kept", bus.overrun,  1);

    // ---- full with simultaneous pop ----
    reset_dut();
    fill16("fp");
    chk("fp_head", bus.rd_data, 0);
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("fp_done",  bus.rx_done, 1);
    chk("fp_ovr",   bus.overrun, 0);
    chk("fp_count", bus.count,   DEPTH);
    chk("fp_full",  bus.full,    1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      chk("fp_order", bus.rd_data, i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("fp_last_a5", bus.rd_data, 8'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fp_empty", bus.nonempty, 0);

    // ---- wrap-around, 1:1 interleave ----
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(i * 7 + 3), 1'b0, 1'b0);
      chk("wrap_count1", bus.count, 1);
      chk("wrap_data",   bus.rd_data, (i * 7 + 3) & 8'hFF);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_count0", bus.count, 0);
    end

    // ---- overrun clear race ----
    reset_dut();
    fill16("race");
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("race_set_wins", bus.overrun, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("race_sticky", bus.overrun, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("race_cleared", bus.overrun, 0);
    chk("race_count",   bus.count,   DEPTH);

    // ---- async reset while in ACK ----
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("ackrst_pre_done", bus.rx_done, 1);
    chk("ackrst_pre_ovr",  bus.overrun, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ackrst_done",     bus.rx_done,  0);
    chk("ackrst_count",    bus.count,    0);
    chk("ackrst_ovr",      bus.overrun,  0);
    chk("ackrst_nonempty", bus.nonempty, 0);
    chk("ackrst_full",     bus.full,     0);
    chk("ackrst_rd_data",  bus.rd_data,  0);

    // ---- random traffic against a queue model ----
    reset_dut();
    q.delete();
    m_ovr     = 0;
    taken     = 1;
    held_once = 0;
    r_rdy     = 1'b0;
    r_data    = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      // Receiver emulation: once a byte is acked, rdy drops now or after one extra cycle.
      if (r_rdy && taken) begin
        if (!held_once && $urandom_range(0, 3) == 0) held_once = 1;
        else begin
          r_rdy     = 1'b0;
          held_once = 0;
        end
      end else if (!r_rdy && $urandom_range(0, 2) != 0) begin
        r_rdy  = 1'b1;
        r_data = 8'($urandom);
        taken  = 0;
      end
      pop_div = ((c / 500) % 2 == 0) ? 5 : 2;
      r_pop   = ($urandom_range(0, pop_div - 1) == 0);
      r_clr   = ($urandom_range(0, 9) == 0);
      drive(r_rdy, r_data, r_pop, r_clr);

      #3;
      exp_head = (q.size() > 0) ? int'(q[0]) : 0;
      chk("rnd_head_same_cycle", bus.rd_data, exp_head);

      pending = r_rdy && !taken;
      if (r_pop && q.size() > 0) void'(q.pop_front());
      if (pending && q.size() >= DEPTH) m_ovr = 1;
      else if (r_clr) m_ovr = 0;
      if (pending) begin
        if (q.size() < DEPTH) q.push_back(r_data);
        taken = 1;
      end

      @(posedge clk);
      #1;
      exp_head = (q.size() > 0) ? int'(q[0]) : 0;
      chk("rnd_done",     bus.rx_done,  pending);
      chk("rnd_count",    bus.count,    q.size());
      chk("rnd_nonempty", bus.nonempty, q.size() > 0);
      chk("rnd_full",     bus.full,     q.size() == DEPTH);
      chk("rnd_ovr",      bus.overrun,  m_ovr);
      chk("rnd_rd_data",  bus.rd_data,  exp_head);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
